// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package seq_div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_addsub_w.sv
// Parameterised ripple-carry add/subtract unit: o_sum = i_a + (i_b ^ {W{i_sub}}) + i_sub.
module addsub_w #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic         w_c;
  logic [W-1:0] w_bx;

  // NOTE: blocking assignments here build the carry chain bit by bit; each
  // iteration must see the carry produced by the previous one.
  always_comb begin
    w_c   = i_sub;
    w_bx  = '0;
    o_sum = '0;
    for (int i = 0; i < W; i++) begin
      w_bx[i]  = i_b[i] ^ i_sub;
      o_sum[i] = i_a[i] ^ w_bx[i] ^ w_c;
      w_c      = (i_a[i] & w_bx[i]) | (w_c & (i_a[i] ^ w_bx[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_q, r_m;
  logic [WIDTH-1:0]   r_quot, r_rem;
  logic               r_dbz;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH:0]     w_shift, w_t;
  logic               w_cout, w_take;

  // Partial remainder stays below the divisor, so A's top bit is always zero
  // and is implicit in the WIDTH-bit register.
  assign w_shift = {r_a, r_q[WIDTH-1]};

  addsub_w #(.W(WIDTH + 1)) u_addsub (
    .i_a    (w_shift),
    .i_b    ({1'b0, r_m}),
    .i_sub  (1'b1),
    .o_sum  (w_t),
    .o_cout (w_cout)
  );

  // No borrow: carry-out set and trial result non-negative.
  assign w_take = w_cout & ~w_t[WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps every path covered, so no latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (r_count == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= divisor;
            r_q     <= dividend;
            r_a     <= '0;
            r_count <= CNT_W'(WIDTH);
            if (divisor == '0) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (r_count != '0) begin
            r_a     <= w_take ? w_t[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_q     <= {r_q[WIDTH-2:0], w_take};
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_quot <= r_q;
            r_rem  <= r_a;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: cycle-level reference model plus directed literal checks.
module tb_seq_div;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_left = cycles of busy remaining; results published when it hits 1.
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
  logic         m_z = 1'b0, m_pz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else begin
      if (m_left == 0) begin
        if (start) begin
          if (divisor == 0) begin
            m_pq = '1; m_pr = dividend; m_pz = 1'b1; m_left = 1;
          end else begin
            m_pq = dividend / divisor; m_pr = dividend % divisor; m_pz = 1'b0; m_left = W + 2;
          end
        end
      end else begin
        m_left--;
      end
      if (m_left == 1) begin
        m_q = m_pq; m_r = m_pr; m_z = m_pz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy,        m_left != 0);
      check("cyc_done", done,        m_left == 1);
      check("cyc_quot", quotient,    m_q);
      check("cyc_rem",  remainder,   m_r);
      check("cyc_dbz",  div_by_zero, m_z);
    end
  end

  // One division: returns results, edges from accept to done, and cycles with busy high.
  task automatic run_div(input int a, input int b,
                         output int q, output int r, output int z,
                         output int lat, output int busyc);
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; busyc = 0;
    forever begin
      if (busy) busyc++;
      if (done || lat > 20) break;
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: no done after %0d edges, expected at %0d", lat, W + 1);
    end
    q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
  endtask

  initial begin
    int q, r, z, lat, busyc, dones, cyc, nd;
    int d_at[3];

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem",  remainder, 0);
    check("rst_dbz",  div_by_zero, 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    run_div(13, 4, q, r, z, lat, busyc);
    check("13/4_q", q, 3); check("13/4_r", r, 1); check("13/4_z", z, 0);
    check("13/4_lat", lat, 5); check("13/4_busy", busyc, 6);

    run_div(15, 1, q, r, z, lat, busyc);
    check("15/1_q", q, 15); check("15/1_r", r, 0);
    run_div(3, 9, q, r, z, lat, busyc);
    check("3/9_q", q, 0); check("3/9_r", r, 3);
    run_div(0, 5, q, r, z, lat, busyc);
    check("0/5_q", q, 0); check("0/5_r", r, 0);

    run_div(7, 0, q, r, z, lat, busyc);
    check("7/0_q", q, 15); check("7/0_r", r, 7); check("7/0_z", z, 1);
    check("7/0_lat", lat, 0); check("7/0_busy", busyc, 1);
    run_div(6, 3, q, r, z, lat, busyc);
    check("6/3_q", q, 2); check("6/3_r", r, 0); check("6/3_z", z, 0);

    // start pulsed mid-calculation with other operands must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk); @(negedge clk);
    start = 1'b1; dividend = 4'd2; divisor = 4'd1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    dones = 0; q = -1; r = -1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin dones++; q = int'(quotient); r = int'(remainder); end
      @(negedge clk);
    end
    check("ign_dones", dones, 1);
    check("ign_q", q, 3); check("ign_r", r, 1);
    check("ign_hold_q", quotient, 3);

    // asynchronous reset in the middle of a calculation
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quot", quotient, 0);
    check("mid_rst_rem",  remainder, 0);
    check("mid_rst_dbz",  div_by_zero, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_div(9, 2, q, r, z, lat, busyc);
    check("9/2_q", q, 4); check("9/2_r", r, 1); check("9/2_lat", lat, 5);

    // start held high: one division every W+3 cycles
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 4'd3;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 60) begin
      if (done) begin
        d_at[nd] = cyc;
        if (nd == 0) begin
          check("held0_q", quotient, 3); check("held0_r", remainder, 2);
          dividend = 4'd14; divisor = 4'd5;
        end else begin
          check("heldn_q", quotient, 2); check("heldn_r", remainder, 4);
        end
        nd++;
      end
      if (nd < 3) begin @(negedge clk); cyc++; end
    end
    start = 1'b0;
    if (nd < 3) begin
      total++; bad++;
      $display("FAIL held_timeout: saw %0d done pulses, expected 3", nd);
    end else begin
      check("held_period1", d_at[1] - d_at[0], W + 3);
      check("held_period2", d_at[2] - d_at[1], W + 3);
    end

    // exhaustive nonzero-divisor sweep against the division identity
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 1; b < (1 << W); b++) begin
        run_div(a, b, q, r, z, lat, busyc);
        check("sweep_inv", q * b + r, a);
        check("sweep_rem_lt", r < b, 1);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
